// File: rtl/baud_pkg.sv
// Shared types and defaults for the UART baud timing path: FSM states, rate indices, divisors.
// Pure declarations, no latency; no handshake of its own.
package baud_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        RELOAD = 2'd3
    } state_t;

    localparam logic [1:0] RATE_9600   = 2'd0;
    localparam logic [1:0] RATE_19200  = 2'd1;
    localparam logic [1:0] RATE_57600  = 2'd2;
    localparam logic [1:0] RATE_115200 = 2'd3;

    // 16x oversample divisors for a 50 MHz clock
    localparam int DEF_DIV0    = 326;
    localparam int DEF_DIV1    = 163;
    localparam int DEF_DIV2    = 54;
    localparam int DEF_DIV3    = 27;
    localparam int DEF_OS_RATE = 16;
    localparam int DEF_TIMEOUT = 65535;

    // A zero divisor would never tick; run it as divide-by-one instead.
    function automatic int div_or_one(input int d);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/baud_tick_div.sv
// Divider plus oversample counter: tick_os every div clocks, tick_bit every OS_RATE tick_os.
// Ticks are combinational from the counters (zero latency); clear holds both counters at 0.
module baud_tick_div #(
    parameter int CNT_W   = 16,
    parameter int OS_RATE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] div,
    output logic             tick_os,
    output logic             tick_bit
);

    localparam int              OS_W    = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [OS_W-1:0]  os_cnt;
    logic             div_end;

    // >= rather than == so a counter past the limit still wraps on the next clock.
    assign div_end  = (div_cnt >= div - CNT_W'(1));
    assign tick_os  = !clear && div_end;
    assign tick_bit = tick_os && (os_cnt == OS_LAST);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (div_end) begin
            div_cnt <= '0;
            os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/baud_rate_ctrl.sv
// Baud rate controller: owns rate_sel, defers cfg_req changes until uart_busy drops, then reloads phase-cleanly.
// cfg_ack >= 2 clocks after cfg_req in RUN; requester holds cfg_req until ack. BAUD_DRAIN_TIMEOUT_EN bounds the drain wait.
module baud_rate_ctrl
    import baud_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int DIV0    = DEF_DIV0,
    parameter int DIV1    = DEF_DIV1,
    parameter int DIV2    = DEF_DIV2,
    parameter int DIV3    = DEF_DIV3,
    parameter int OS_RATE = DEF_OS_RATE
`ifdef BAUD_DRAIN_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cfg_req,
    input  logic [1:0] cfg_sel,
    output logic       cfg_ack,
    input  logic       uart_busy,
    output logic [1:0] rate_sel,
    output logic       tick_os,
    output logic       tick_bit,
    output logic       cfg_pending
`ifdef BAUD_DRAIN_TIMEOUT_EN
    ,
    output logic       cfg_timeout
`endif
);

    function automatic logic [CNT_W-1:0] div_lut(input logic [1:0] sel);
        logic [CNT_W-1:0] d;
        case (sel)
            RATE_9600:  d = CNT_W'(div_or_one(DIV0));
            RATE_19200: d = CNT_W'(div_or_one(DIV1));
            RATE_57600: d = CNT_W'(div_or_one(DIV2));
            default:    d = CNT_W'(div_or_one(DIV3));
        endcase
        return d;
    endfunction

    state_t           state;
    logic [1:0]       pending_sel;
    logic [CNT_W-1:0] div;
    logic             clear;
    logic             drain_done;

    assign clear = !(state == RUN || state == DRAIN);

`ifdef BAUD_DRAIN_TIMEOUT_EN
    logic [15:0] drain_cnt;
    assign drain_done = !uart_busy || (drain_cnt == 16'(TIMEOUT - 1));
`else
    assign drain_done = !uart_busy;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rate_sel    <= RATE_9600;
            pending_sel <= RATE_9600;
            div         <= div_lut(RATE_9600);
            cfg_ack     <= 1'b0;
            cfg_pending <= 1'b0;
`ifdef BAUD_DRAIN_TIMEOUT_EN
            drain_cnt   <= '0;
            cfg_timeout <= 1'b0;
`endif
        end else begin
            cfg_ack     <= 1'b0;
            cfg_pending <= 1'b0;
            div         <= div_lut(rate_sel);
`ifdef BAUD_DRAIN_TIMEOUT_EN
            drain_cnt   <= '0;
            cfg_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (cfg_req) begin
                        pending_sel <= cfg_sel;
                        cfg_pending <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (drain_done) begin
                        state       <= RELOAD;
                        cfg_ack     <= 1'b1;
                        cfg_pending <= 1'b1;
`ifdef BAUD_DRAIN_TIMEOUT_EN
                        cfg_timeout <= uart_busy;
`endif
                    end else begin
                        cfg_pending <= 1'b1;
`ifdef BAUD_DRAIN_TIMEOUT_EN
                        drain_cnt   <= drain_cnt + 16'd1;
`endif
                    end
                end
                RELOAD: begin
                    // Divisor follows the new rate so the first RUN cycle already counts against it.
                    rate_sel <= pending_sel;
                    div      <= div_lut(pending_sel);
                    state    <= en ? RUN : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    baud_tick_div #(
        .CNT_W   (CNT_W),
        .OS_RATE (OS_RATE)
    ) u_tick_div (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .div      (div),
        .tick_os  (tick_os),
        .tick_bit (tick_bit)
    );

endmodule

// File: tb/tb_baud_rate_ctrl.sv
// Bench for baud_rate_ctrl: directed handshake scenarios plus randomized requests against a cycle reference model.
module tb_baud_rate_ctrl;

    localparam int OS = 16;
`ifdef BAUD_DRAIN_TIMEOUT_EN
    localparam int TO = 100;
`endif

    logic       clk = 1'b0;
    logic       rst, en, cfg_req, uart_busy;
    logic [1:0] cfg_sel, rate_sel;
    logic       cfg_ack, tick_os, tick_bit, cfg_pending;
`ifdef BAUD_DRAIN_TIMEOUT_EN
    logic       cfg_timeout;
    bit         saw_to;
`endif

    int errors = 0, checks = 0, cyc = 0;
    int n_os, n_bit, last_os, prev_os, ack_cyc, lat;
    bit saw_ack;

    // Reference model: mode 0 off, 1 run, 2 drain, 3 reload; phase = clocks since the divider restarted.
    int m_mode, m_rate, m_pend, m_phase, m_dcnt;
    bit m_tflag;

    always #5 clk = ~clk;

    baud_rate_ctrl #(
        .CNT_W (16)
`ifdef BAUD_DRAIN_TIMEOUT_EN
        , .TIMEOUT (TO)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_req     (cfg_req),
        .cfg_sel     (cfg_sel),
        .cfg_ack     (cfg_ack),
        .uart_busy   (uart_busy),
        .rate_sel    (rate_sel),
        .tick_os     (tick_os),
        .tick_bit    (tick_bit),
        .cfg_pending (cfg_pending)
`ifdef BAUD_DRAIN_TIMEOUT_EN
        , .cfg_timeout (cfg_timeout)
`endif
    );

    function automatic int div_of(input int r);
        case (r)
            0:       return 326;
            1:       return 163;
            2:       return 54;
            default: return 27;
        endcase
    endfunction

    // Cycles from the first cfg_req cycle (in RUN) to the ack cycle, with busy high for b cycles.
    function automatic int exp_lat(input int b);
        int l;
        l = (b <= 1) ? 2 : b + 1;
`ifdef BAUD_DRAIN_TIMEOUT_EN
        if (b > TO) l = TO + 1;
`endif
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic advance();
        if (!rst) begin
            m_mode = 0; m_rate = 0; m_pend = 0; m_phase = 0; m_dcnt = 0; m_tflag = 0;
        end else begin
            case (m_mode)
                0: begin
                    m_phase = 0;
                    if (en) m_mode = 1;
                end
                1: begin
                    if (!en) begin
                        m_mode = 0; m_phase = 0;
                    end else begin
                        m_phase++;
                        if (cfg_req) begin
                            m_pend = cfg_sel; m_mode = 2; m_dcnt = 0;
                        end
                    end
                end
                2: begin
                    if (!en) begin
                        m_mode = 0; m_phase = 0;
                    end else begin
                        m_phase++;
                        m_tflag = 0;
`ifdef BAUD_DRAIN_TIMEOUT_EN
                        if (uart_busy && m_dcnt == TO - 1) begin
                            m_mode = 3; m_tflag = 1;
                        end else
`endif
                        if (!uart_busy) m_mode = 3;
                        else m_dcnt++;
                    end
                end
                default: begin
                    m_rate = m_pend; m_phase = 0;
                    m_mode = en ? 1 : 0;
                end
            endcase
        end
    endtask

    task automatic step();
        int  d;
        logic e_os, e_bit;
        @(negedge clk);
        d     = div_of(m_rate);
        e_os  = (m_mode == 1 || m_mode == 2) && (m_phase % d == d - 1);
        e_bit = e_os && ((((m_phase + 1) / d) % OS) == 0);
        chk("tick_os", tick_os, e_os);
        chk("tick_bit", tick_bit, e_bit);
        chk("cfg_ack", cfg_ack, m_mode == 3);
        chk("cfg_pending", cfg_pending, m_mode >= 2);
        chk("rate_sel", rate_sel, m_rate);
`ifdef BAUD_DRAIN_TIMEOUT_EN
        chk("cfg_timeout", cfg_timeout, m_mode == 3 && m_tflag);
        if (cfg_timeout === 1'b1) saw_to = 1;
`endif
        saw_ack = (cfg_ack === 1'b1);
        if (saw_ack) ack_cyc = cyc;
        if (tick_os === 1'b1) begin prev_os = last_os; last_os = cyc; n_os++; end
        if (tick_bit === 1'b1) n_bit++;
        @(posedge clk);
        advance();
        cyc++;
        #1;
    endtask

    // Issue one request from RUN and hold it until ack; busy stays high for busy_n cycles.
    task automatic request(input logic [1:0] sel, input int busy_n);
        bit done;
        done = 0; lat = -1;
        cfg_req = 1'b1; cfg_sel = sel;
        for (int i = 0; i < busy_n + 40 && !done; i++) begin
            uart_busy = (i < busy_n);
            step();
            if (saw_ack) begin done = 1; lat = i; end
        end
        cfg_req = 1'b0; uart_busy = 1'b0;
        chk("ack_latency", lat, exp_lat(busy_n));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; cfg_req = 1'b0; cfg_sel = 2'd0; uart_busy = 1'b0;
        n_os = 0; n_bit = 0; last_os = 0; prev_os = 0; ack_cyc = 0; saw_ack = 0;
        m_mode = 0; m_rate = 0; m_pend = 0; m_phase = 0; m_dcnt = 0; m_tflag = 0;
`ifdef BAUD_DRAIN_TIMEOUT_EN
        saw_to = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        repeat (3) step();

        // Default rate: 326-clock oversample period, 5216-clock bit period.
        rst = 1'b1; en = 1'b1; n_os = 0; n_bit = 0;
        repeat (2 * 5216 + 1) step();
        chk("os_count_div0", n_os, 32);
        chk("bit_count_div0", n_bit, 2);
        chk("os_period_div0", last_os - prev_os, 326);

        // Idle UART: fastest handshake, then 27-clock period from the reload cycle.
        request(2'd3, 0);
        repeat (60) step();
        chk("first_os_after_reload", prev_os - ack_cyc, 27);
        chk("os_period_div3", last_os - prev_os, 27);
        chk("rate_after_req3", rate_sel, 2'd3);
        repeat (27 * OS * 2) step();

        // Busy frame for 1000 cycles: old rate keeps ticking, ack one cycle after busy falls.
        request(2'd2, 1000);
        repeat (120) step();
        chk("rate_after_req2", rate_sel, 2'd2);
        chk("os_period_div2", last_os - prev_os, 54);

        // en dropped mid-drain: no ack, ticks stop; served after re-enable.
        cfg_req = 1'b1; cfg_sel = 2'd1; uart_busy = 1'b1;
        repeat (20) step();
        en = 1'b0;
        step();
        n_os = 0; saw_ack = 0;
        repeat (10) step();
        chk("ticks_while_disabled", n_os, 0);
        en = 1'b1; uart_busy = 1'b0; lat = -1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            step();
            if (saw_ack) lat = i;
        end
        cfg_req = 1'b0;
        chk("ack_after_reenable", lat, 3);
        step();
        chk("rate_after_reenable", rate_sel, 2'd1);

        // Reset in RUN at the fastest rate, then back to the 326-clock period.
        request(2'd3, 0);
        repeat (100) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rate_after_reset", rate_sel, 2'd0);
        repeat (700) step();
        chk("os_period_after_reset", last_os - prev_os, 326);

        // Reset in DRAIN loses the request.
        cfg_req = 1'b1; cfg_sel = 2'd2; uart_busy = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        step();
        rst = 1'b1; cfg_req = 1'b0; uart_busy = 1'b0;
        repeat (3) step();
        chk("rate_after_drain_reset", rate_sel, 2'd0);

`ifdef BAUD_DRAIN_TIMEOUT_EN
        saw_to = 0;
        request(2'd1, 300);
        chk("timeout_pulse", saw_to, 1'b1);
`endif

        // Randomized traffic: gaps, short disables, requests with random busy durations.
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 300)) step();
            if ($urandom_range(0, 4) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 6)) step();
                en = 1'b1;
                step();
            end
            request(2'($urandom_range(0, 3)), int'($urandom_range(0, 60)));
        end
        repeat (50) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/baud_rate_ctrl.md
Name: baud_rate_ctrl

Overview:
- Controller for the UART baud timing path.
- Owns the active rate selection and accepts rate-change requests over a req/ack handshake.
- Defers every change until the UART reports idle, then reloads the divider phase-cleanly.
- Produces a one-cycle oversample tick (tick_os) and a one-cycle bit tick (tick_bit) for the TX/RX engines.

Parameters:
- CNT_W, 16, width of divider counter.
- DIV0, 326, clocks per oversample tick for sel 2'b00 (9600 baud at 50 MHz, 16x).
- DIV1, 163, clocks per oversample tick for sel 2'b01 (19200).
- DIV2, 54, clocks per oversample tick for sel 2'b10 (57600).
- DIV3, 27, clocks per oversample tick for sel 2'b11 (115200).
- OS_RATE, 16, oversample ticks per bit tick (2..16).
- TIMEOUT, 65535, drain timeout in clocks (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low.
- en  input  1  enable; low holds counters at 0 and suppresses ticks.
- cfg_req  input  1  rate-change request; level, held until cfg_ack.
- cfg_sel  input  2  requested rate index, valid while cfg_req high.
- cfg_ack  output  1  one-cycle pulse; change applied.
- uart_busy  input  1  high while any frame is in flight.
- rate_sel  output  2  currently active rate index.
- tick_os  output  1  one-cycle oversample strobe.
- tick_bit  output  1  one-cycle bit strobe.
- cfg_pending  output  1  high in DRAIN and RELOAD.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-low, sampled on posedge clk.
- Reset values: state IDLE, rate_sel 2'b00, div_cnt 0, os_cnt 0, pending_sel 0, all outputs 0.
- Divisor is a registered lookup of rate_sel; a table value of 0 is treated as 1.
- States:
  - IDLE: en low. Counters held at 0, no ticks, cfg_req ignored. en high -> RUN next cycle.
  - RUN: normal tick generation. If cfg_req is high, latch cfg_sel into pending_sel -> DRAIN.
  - DRAIN: ticks continue at the old rate; cfg_req not re-sampled. uart_busy low -> RELOAD.
  - RELOAD (one cycle): rate_sel <= pending_sel, div_cnt <= 0, os_cnt <= 0, cfg_ack = 1, no ticks -> RUN.
- en low in any state -> IDLE next cycle. A pending change is dropped with no ack; the requester keeps cfg_req high and is served after re-enable.
- Divider:
  - div_cnt counts 0..div-1.
  - tick_os = 1 in the cycle div_cnt == div-1; div_cnt wraps to 0 the same cycle.
  - Arithmetic is CNT_W unsigned.
- Bit tick:
  - os_cnt advances on each tick_os, wraps at OS_RATE-1.
  - tick_bit = tick_os && os_cnt == OS_RATE-1.
  - Bit period = div*OS_RATE clocks; tick_bit is always coincident with a tick_os.
- Handshake latency: minimum 2 cycles from cfg_req sampled high in RUN to cfg_ack (RUN->DRAIN->RELOAD).
  - First tick_os after reload comes div cycles after RELOAD.
  - A request equal to the current rate still runs the full sequence, which restarts the phase.
- cfg_req held high after cfg_ack: treated as a new request in the next RUN cycle. The requester must drop cfg_req in the cycle after ack.
- Simultaneous uart_busy fall and a tick_os in DRAIN: the tick is emitted, then RELOAD.
- Reset mid-DRAIN: request lost, rate_sel returns to 2'b00.

Optional Feature:
- Macro: BAUD_DRAIN_TIMEOUT_EN.
- Defined:
  - A 16-bit drain counter runs in DRAIN.
  - When uart_busy is still high after TIMEOUT cycles, force RELOAD.
  - In that RELOAD cycle, pulse extra output cfg_timeout (1 bit, reset 0) alongside cfg_ack.
- Undefined: DRAIN waits indefinitely; no cfg_timeout port, no counter logic.

Decomposition:
- Package baud_pkg: state enum (IDLE, RUN, DRAIN, RELOAD), 2-bit rate index constants (RATE_9600..RATE_115200), default DIV values.
- One sub-module, baud_tick_div: div_cnt plus os_cnt, with load/clear input, producing tick_os/tick_bit. The FSM stays in baud_rate_ctrl.

Test Plan:
- Reset, en=1, DIV0=326 -> tick_os every 326 clocks, tick_bit every 5216, rate_sel=0, no ack.
- cfg_req sel=3 with uart_busy=0 -> cfg_ack 2 cycles later, rate_sel=3, first tick_os 27 clocks after RELOAD, then period 27.
- cfg_req sel=2 with uart_busy=1 for 1000 cycles -> old-rate ticks continue, cfg_pending=1, ack 1 cycle after busy falls, rate_sel=2.
- en dropped in DRAIN -> IDLE, no ack, ticks stop. en re-raised with cfg_req still high -> ack, rate applied.
- rst low mid-RUN at rate 3 -> next cycle all outputs 0, rate_sel=0. After release, 326-clock period.
- With BAUD_DRAIN_TIMEOUT_EN, TIMEOUT=100, busy stuck high -> cfg_ack and cfg_timeout pulse together 100 cycles after entering DRAIN.
